// File: rtl/updn_ctr_mod_if.sv
`default_nettype none
// ============================================================================
// Module      : updn_ctr_mod_if
// Description : Control/status bundle for the programmable up/down counter.
//               The master drives load/count controls and observes status;
//               the slave is the counter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface updn_ctr_mod_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic [WIDTH-1:0]  data;
    logic              load;
    logic              cen;
    logic              up_dn;
    logic [STEP_W-1:0] step;
    logic              mode_sat;
    logic              clr_sticky;
    logic [WIDTH-1:0]  count;
    logic              tercnt;
    logic              wrap_pulse;
    logic              sat_pulse;
    logic              ovf_sticky;

    modport master (
        output data, load, cen, up_dn, step, mode_sat, clr_sticky,
        input  count, tercnt, wrap_pulse, sat_pulse, ovf_sticky
    );

    modport slave (
        input  data, load, cen, up_dn, step, mode_sat, clr_sticky,
        output count, tercnt, wrap_pulse, sat_pulse, ovf_sticky
    );
endinterface
`default_nettype wire

// File: rtl/updn_ctr_mod.sv
`default_nettype none
// ============================================================================
// Module      : updn_ctr_mod
// Description : Up/down counter with programmable modulus, variable step,
//               wrap or saturate mode, direction-aware terminal count,
//               registered wrap/saturate event pulses and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module updn_ctr_mod #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP_W  = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    updn_ctr_mod_if.slave bus
);

    // Wide enough to hold count+step without losing the carry before bound checks.
    localparam int              c_IW    = WIDTH + STEP_W + 1;
    localparam logic [c_IW-1:0] c_MAX   = c_IW'(MAX_VAL);
    localparam logic [c_IW-1:0] c_MOD   = c_IW'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] c_MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_sat;
    logic             r_sticky;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_sat_nxt;
    logic             w_sticky_nxt;

    logic [c_IW-1:0]  w_cnt_x;
    logic [c_IW-1:0]  w_step_x;
    logic [c_IW-1:0]  w_sum;
    logic [c_IW-1:0]  w_deficit;
    logic [c_IW-1:0]  w_def_rem;
    logic [c_IW-1:0]  w_up_wrap;
    logic [c_IW-1:0]  w_dn_wrap;
    logic             w_up_over;
    logic             w_dn_under;
    logic [WIDTH-1:0] w_load_val;

    assign w_cnt_x    = c_IW'(r_count);
    assign w_step_x   = c_IW'(bus.step);
    assign w_sum      = w_cnt_x + w_step_x;
    assign w_up_over  = (w_sum > c_MAX);
    assign w_dn_under = (w_step_x > w_cnt_x);
    // A step may exceed the modulus several times over, so a true remainder is needed.
    assign w_up_wrap  = w_sum % c_MOD;
    // Underflow: fold the magnitude of the shortfall back from the top of the range.
    assign w_deficit  = w_step_x - w_cnt_x;
    assign w_def_rem  = w_deficit % c_MOD;
    assign w_dn_wrap  = (w_def_rem == '0) ? '0 : (c_MOD - w_def_rem);
    assign w_load_val = (bus.data > c_MAX_W) ? c_MAX_W : bus.data;

    // Next-state selection: load beats count, count beats hold; sticky set beats clear.
    always_comb begin
        w_count_nxt  = r_count;
        w_wrap_nxt   = 1'b0;
        w_sat_nxt    = 1'b0;
        w_sticky_nxt = bus.clr_sticky ? 1'b0 : r_sticky;
        if (!bus.load) begin
            w_count_nxt = w_load_val;
        end else if (bus.cen) begin
            if (bus.up_dn) begin
                if (!w_up_over) begin
                    w_count_nxt = WIDTH'(w_sum);
                end else if (bus.mode_sat) begin
                    w_count_nxt = c_MAX_W;
                    w_sat_nxt   = 1'b1;
                end else begin
                    w_count_nxt = WIDTH'(w_up_wrap);
                    w_wrap_nxt  = 1'b1;
                end
            end else begin
                if (!w_dn_under) begin
                    w_count_nxt = WIDTH'(w_cnt_x - w_step_x);
                end else if (bus.mode_sat) begin
                    w_count_nxt = '0;
                    w_sat_nxt   = 1'b1;
                end else begin
                    w_count_nxt = WIDTH'(w_dn_wrap);
                    w_wrap_nxt  = 1'b1;
                end
            end
            if (w_wrap_nxt || w_sat_nxt) begin
                w_sticky_nxt = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_sat    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_wrap   <= w_wrap_nxt;
            r_sat    <= w_sat_nxt;
            r_sticky <= w_sticky_nxt;
        end
    end

    assign bus.count      = r_count;
    assign bus.wrap_pulse = r_wrap;
    assign bus.sat_pulse  = r_sat;
    assign bus.ovf_sticky = r_sticky;
    // Terminal count tracks direction combinationally so software can flip up_dn mid-cycle.
    assign bus.tercnt     = (bus.up_dn && (r_count == c_MAX_W)) ||
                            (!bus.up_dn && (r_count == '0));

endmodule
`default_nettype wire

// File: tb/tb_updn_ctr_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_updn_ctr_mod
// Description : Directed self-checking bench for updn_ctr_mod (WIDTH=4,
//               MAX_VAL=9). A reference model pushes expected state into a
//               scoreboard queue as each edge's stimulus is applied; the
//               entry is popped and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updn_ctr_mod;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;
    localparam int STEP_W  = 4;

    typedef struct {
        string      tag;
        logic [6:0] st;   // {count[3:0], wrap, sat, sticky}
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    int   n_checks;
    int   n_fails;

    int m_count;
    int m_wrap;
    int m_sat;
    int m_sticky;

    updn_ctr_mod_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    updn_ctr_mod #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .STEP_W(STEP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: advance one edge using plain integer arithmetic.
    task automatic model_edge();
        int nxt;
        int ev;
        ev = 0;
        if (!reset) begin
            m_count = 0; m_wrap = 0; m_sat = 0; m_sticky = 0;
        end else if (!bus.load) begin
            m_count = (int'(bus.data) > MAX_VAL) ? MAX_VAL : int'(bus.data);
            m_wrap = 0; m_sat = 0;
            if (bus.clr_sticky) m_sticky = 0;
        end else if (bus.cen) begin
            m_wrap = 0; m_sat = 0;
            nxt = bus.up_dn ? (m_count + int'(bus.step)) : (m_count - int'(bus.step));
            if (nxt > MAX_VAL || nxt < 0) begin
                ev = 1;
                if (bus.mode_sat) begin
                    m_count = (nxt < 0) ? 0 : MAX_VAL;
                    m_sat   = 1;
                end else begin
                    m_count = ((nxt % (MAX_VAL + 1)) + (MAX_VAL + 1)) % (MAX_VAL + 1);
                    m_wrap  = 1;
                end
            end else begin
                m_count = nxt;
            end
            if (ev != 0) m_sticky = 1;
            else if (bus.clr_sticky) m_sticky = 0;
        end else begin
            m_wrap = 0; m_sat = 0;
            if (bus.clr_sticky) m_sticky = 0;
        end
    endtask

    task automatic check_tercnt(input string tag);
        logic exp_t_v;
        exp_t_v = (bus.up_dn && m_count == MAX_VAL) || (!bus.up_dn && m_count == 0);
        n_checks++;
        assert (bus.tercnt === exp_t_v) else begin
            n_fails++;
            $error("FAIL %s tercnt: observed %0b expected %0b", tag, bus.tercnt, exp_t_v);
        end
    endtask

    // Push the expected post-edge state, clock once, then pop and compare.
    task automatic tick(input string tag);
        exp_t e;
        exp_t got;
        logic [6:0] obs;
        model_edge();
        e.tag = tag;
        e.st  = {4'(m_count), 1'(m_wrap), 1'(m_sat), 1'(m_sticky)};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        obs = {bus.count, bus.wrap_pulse, bus.sat_pulse, bus.ovf_sticky};
        n_checks++;
        assert (obs === got.st) else begin
            n_fails++;
            $error("FAIL %s: observed cnt=%0d w=%0b s=%0b o=%0b expected cnt=%0d w=%0b s=%0b o=%0b",
                   got.tag, obs[6:3], obs[2], obs[1], obs[0],
                   got.st[6:3], got.st[2], got.st[1], got.st[0]);
        end
        check_tercnt(got.tag);
    endtask

    initial begin
        n_checks = 0; n_fails = 0;
        m_count = 0; m_wrap = 0; m_sat = 0; m_sticky = 0;
        reset = 1'b0;
        bus.data = 4'd5; bus.load = 1'b0; bus.cen = 1'b0; bus.up_dn = 1'b1;
        bus.step = '0; bus.mode_sat = 1'b0; bus.clr_sticky = 1'b0;

        // Reset held over two edges while load is requested
        tick("reset0");
        tick("reset1");

        // Load 5
        reset = 1'b1;
        tick("load5");
        bus.load = 1'b1;

        // Wrap up 8+3 -> 1
        bus.data = 4'd8; bus.load = 1'b0; tick("load8");
        bus.load = 1'b1; bus.cen = 1'b1; bus.up_dn = 1'b1; bus.step = 4'd3;
        tick("wrap_up");
        bus.cen = 1'b0;
        tick("wrap_up_hold");

        // Wrap down 1-4 -> 7
        bus.cen = 1'b1; bus.up_dn = 1'b0; bus.step = 4'd4;
        tick("wrap_dn");

        // Saturate down from 2 by 5, twice
        bus.data = 4'd2; bus.load = 1'b0; tick("load2_pri");
        bus.load = 1'b1; bus.step = 4'd5; bus.mode_sat = 1'b1;
        tick("sat_dn");
        tick("sat_dn_again");

        // Load clamp with count enable also active
        bus.data = 4'd15; bus.load = 1'b0; bus.up_dn = 1'b1;
        tick("load_clamp");
        bus.load = 1'b1; bus.cen = 1'b0;
        #1; check_tercnt("ter_up");
        bus.up_dn = 1'b0;
        #1; check_tercnt("ter_dn");

        // Sticky clear without event, then clear racing a saturation
        bus.clr_sticky = 1'b1;
        tick("sticky_clr");
        bus.up_dn = 1'b1; bus.step = 4'd1; bus.mode_sat = 1'b1; bus.cen = 1'b1;
        tick("sticky_race");
        bus.clr_sticky = 1'b0;

        // Multi-modulus wraps and step 0
        bus.mode_sat = 1'b0; bus.step = 4'd15;
        tick("wrap_up_big");
        bus.data = 4'd0; bus.load = 1'b0; tick("load0");
        bus.load = 1'b1; bus.up_dn = 1'b0;
        tick("wrap_dn_big");
        bus.step = 4'd0;
        tick("step0");

        // Mid-cycle reset has no effect until the edge
        bus.data = 4'd6; bus.load = 1'b0; tick("load6");
        bus.load = 1'b1; bus.up_dn = 1'b1; bus.step = 4'd1; bus.cen = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        assert (bus.count === 4'd6) else begin
            n_fails++;
            $error("FAIL midcycle_reset: observed %0d expected 6", bus.count);
        end
        tick("sync_reset");
        reset = 1'b1;
        tick("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
